// File: rtl/md_ctrl.sv
// Multi-cycle multiply/divide controller for the E stage: counted busy sequence,
// HI/LO architectural registers, and the D-stage stall for dependent HI/LO ops.
module md_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        e_valid,
  input  logic [3:0]  e_md_op,
  input  logic [31:0] e_rs,
  input  logic [31:0] e_rt,
  input  logic        d_is_md,
  output logic        md_start,
  output logic        md_busy,
  output logic [31:0] md_rd,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        d_stall
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;

  localparam logic [5:0] MULT_CNT = 6'(MULT_CYCLES);
  localparam logic [5:0] DIV_CNT  = 6'(DIV_CYCLES);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] p_hi_q, p_hi_d;
  logic [31:0] p_lo_q, p_lo_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        is_muldiv;
  logic        idle;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [63:0] prod;
  logic [31:0] quot;
  logic [31:0] rem;

  assign idle      = (state_q == ST_IDLE);
  assign is_muldiv = (e_md_op >= OP_MULT) && (e_md_op <= OP_DIVU);
  assign md_start  = e_valid & is_muldiv & idle;
  assign md_busy   = ~idle;
  assign d_stall   = d_is_md & (md_start | md_busy);
  assign hi        = hi_q;
  assign lo        = lo_q;

  always_comb begin
    case (e_md_op)
      OP_MFHI: md_rd = hi_q;
      OP_MFLO: md_rd = lo_q;
      default: md_rd = 32'd0;
    endcase
  end

  assign prod_s = $signed({{32{e_rs[31]}}, e_rs}) * $signed({{32{e_rt[31]}}, e_rt});
  assign prod_u = {32'd0, e_rs} * {32'd0, e_rt};
  assign prod   = (e_md_op == OP_MULT) ? prod_s : prod_u;

  // Divide by zero re-latches the current HI/LO so completion leaves them unchanged;
  // the single signed overflow case (-2^31 / -1) is pinned to the wrapped result.
  always_comb begin
    quot = lo_q;
    rem  = hi_q;
    if (e_rt != 32'd0) begin
      if (e_md_op == OP_DIV) begin
        if ((e_rs == 32'h8000_0000) && (e_rt == 32'hFFFF_FFFF)) begin
          quot = 32'h8000_0000;
          rem  = 32'd0;
        end else begin
          quot = $signed(e_rs) / $signed(e_rt);
          rem  = $signed(e_rs) % $signed(e_rt);
        end
      end else begin
        quot = e_rs / e_rt;
        rem  = e_rs % e_rt;
      end
    end
  end

  always_comb begin
    // NOTE: every next-state signal starts from its current value so no path leaves it unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    p_hi_d  = p_hi_q;
    p_lo_d  = p_lo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (md_start) begin
          if ((e_md_op == OP_MULT) || (e_md_op == OP_MULTU)) begin
            state_d = ST_MUL;
            cnt_d   = MULT_CNT;
            p_hi_d  = prod[63:32];
            p_lo_d  = prod[31:0];
          end else begin
            state_d = ST_DIV;
            cnt_d   = DIV_CNT;
            p_hi_d  = rem;
            p_lo_d  = quot;
          end
        end else if (e_valid && (e_md_op == OP_MTHI)) begin
          hi_d = e_rs;
        end else if (e_valid && (e_md_op == OP_MTLO)) begin
          lo_d = e_rs;
        end
      end
      ST_MUL, ST_DIV: begin
        if (cnt_q == 6'd1) begin
          hi_d    = p_hi_q;
          lo_d    = p_lo_q;
          cnt_d   = 6'd0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 6'd0;
      p_hi_q  <= 32'd0;
      p_lo_q  <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_hi_q  <= p_hi_d;
      p_lo_q  <= p_lo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_md_ctrl.sv
// Scoreboard bench for md_ctrl: the driver runs a cycle-level HI/LO model and queues
// expected completions and reads; a negedge monitor pops and compares them.
module tb_md_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        e_valid;
  logic [3:0]  e_md_op;
  logic [31:0] e_rs;
  logic [31:0] e_rt;
  logic        d_is_md;
  logic        md_start;
  logic        md_busy;
  logic [31:0] md_rd;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        d_stall;

  always #5 clk = ~clk;

  md_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk      (clk),
    .reset    (reset),
    .e_valid  (e_valid),
    .e_md_op  (e_md_op),
    .e_rs     (e_rs),
    .e_rt     (e_rt),
    .d_is_md  (d_is_md),
    .md_start (md_start),
    .md_busy  (md_busy),
    .md_rd    (md_rd),
    .hi       (hi),
    .lo       (lo),
    .d_stall  (d_stall)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          n;
  } md_exp_t;

  md_exp_t     mdq[$];
  logic [31:0] rdq[$];
  int          n_vec  = 0;
  int          n_fail = 0;

  // Architectural model: current HI/LO plus one pending result and the cycle it lands.
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  bit          m_pend;
  int          m_commit;
  int          cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] rs,
                                             input logic [31:0] rt, input logic [31:0] cur_hi,
                                             input logic [31:0] cur_lo);
    longint          a, b;
    longint unsigned ua, ub;
    logic [63:0]     r;
    a  = $signed(rs);
    b  = $signed(rt);
    ua = {32'd0, rs};
    ub = {32'd0, rt};
    r  = {cur_hi, cur_lo};
    case (op)
      4'd1: r = a * b;
      4'd2: r = ua * ub;
      4'd3: if (rt != 0) r = {32'(a % b), 32'(a / b)};
      4'd4: if (rt != 0) r = {32'(ua % ub), 32'(ua / ub)};
      default: r = {cur_hi, cur_lo};
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic issue(input logic v, input logic [3:0] op, input logic [31:0] rs,
                       input logic [31:0] rt, input logic dmd);
    bit          busy, start;
    logic [63:0] res;
    int          n;
    e_valid = v;
    e_md_op = op;
    e_rs    = rs;
    e_rt    = rt;
    d_is_md = dmd;
    if (m_pend && cyc >= m_commit) begin
      m_hi   = m_phi;
      m_lo   = m_plo;
      m_pend = 1'b0;
    end
    busy  = m_pend;
    start = v && (op >= 4'd1) && (op <= 4'd4) && !busy;
    if (op == 4'd7) rdq.push_back(m_hi);
    else if (op == 4'd8) rdq.push_back(m_lo);
    @(negedge clk);
    check("md_busy", 32'(md_busy), 32'(busy));
    check("md_start", 32'(md_start), 32'(start));
    check("d_stall", 32'(d_stall), 32'(dmd && (start || busy)));
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
    if (start) begin
      res      = ref_result(op, rs, rt, m_hi, m_lo);
      n        = (op <= 4'd2) ? MULT_N : DIV_N;
      m_phi    = res[63:32];
      m_plo    = res[31:0];
      m_pend   = 1'b1;
      m_commit = cyc + n + 1;
      mdq.push_back('{hi: res[63:32], lo: res[31:0], n: n});
    end else if (v && !busy && op == 4'd5) begin
      m_hi = rs;
    end else if (v && !busy && op == 4'd6) begin
      m_lo = rs;
    end
    tick();
  endtask

  task automatic idle_cycles(input int n, input logic dmd);
    for (int k = 0; k < n; k++) issue(1'b0, 4'd0, 32'd0, 32'd0, dmd);
  endtask

  task automatic do_reset(input int n);
    reset   = 1'b1;
    e_valid = 1'b0;
    e_md_op = 4'd0;
    e_rs    = 32'd0;
    e_rt    = 32'd0;
    d_is_md = 1'b0;
    mdq.delete();
    rdq.delete();
    repeat (n) tick();
    reset  = 1'b0;
    m_hi   = 32'd0;
    m_lo   = 32'd0;
    m_pend = 1'b0;
  endtask

  // Monitor: a falling md_busy presents a completed result; an mfhi/mflo presents md_rd.
  int      busy_run = 0;
  md_exp_t mon_e;

  always @(negedge clk) begin
    if (reset) begin
      busy_run = 0;
    end else begin
      if (md_busy) begin
        busy_run++;
        if (busy_run > 4 * DIV_N) begin
          n_vec++;
          n_fail++;
          $display("FAIL busy_timeout: busy for %0d cycles, limit %0d", busy_run, 4 * DIV_N);
          busy_run = 0;
        end
      end else if (busy_run > 0) begin
        if (mdq.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL completion: busy ended after %0d cycles with nothing expected", busy_run);
        end else begin
          mon_e = mdq.pop_front();
          check("busy_cycles", 32'(busy_run), 32'(mon_e.n));
          check("commit_hi", hi, mon_e.hi);
          check("commit_lo", lo, mon_e.lo);
        end
        busy_run = 0;
      end
      if (e_md_op == 4'd7 || e_md_op == 4'd8) begin
        if (rdq.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL md_rd: read op %0d with no expected value queued", e_md_op);
        end else begin
          check("md_rd", md_rd, rdq.pop_front());
        end
      end else begin
        check("md_rd_zero", md_rd, 32'd0);
      end
    end
  end

  initial begin
    logic [3:0]  op;
    logic        v;
    logic [31:0] rs, rt;
    cyc    = 0;
    m_hi   = 32'd0;
    m_lo   = 32'd0;
    m_phi  = 32'd0;
    m_plo  = 32'd0;
    m_pend = 1'b0;
    m_commit = 0;
    do_reset(2);
    idle_cycles(1, 1'b0);

    // mult with a dependent D instruction: stall for start + 5 busy cycles
    issue(1'b1, 4'd1, 32'hFFFF_FFFF, 32'd2, 1'b1);
    idle_cycles(MULT_N + 2, 1'b1);
    issue(1'b1, 4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
    idle_cycles(MULT_N + 1, 1'b0);

    issue(1'b1, 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    idle_cycles(DIV_N + 1, 1'b0);
    issue(1'b1, 4'd4, 32'd7, 32'd2, 1'b0);
    idle_cycles(DIV_N + 1, 1'b0);
    issue(1'b1, 4'd3, 32'h0000_1234, 32'd0, 1'b0);
    idle_cycles(DIV_N + 1, 1'b0);
    issue(1'b1, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    idle_cycles(DIV_N + 1, 1'b0);

    issue(1'b1, 4'd5, 32'h1234_5678, 32'd0, 1'b0);
    issue(1'b1, 4'd7, 32'd0, 32'd0, 1'b0);
    issue(1'b1, 4'd8, 32'd0, 32'd0, 1'b0);

    // mtlo while busy is dropped; back-to-back mult starts the cycle busy falls
    issue(1'b1, 4'd1, 32'd3, 32'd4, 1'b0);
    issue(1'b1, 4'd6, 32'hDEAD_BEEF, 32'd0, 1'b0);
    idle_cycles(MULT_N - 1, 1'b0);
    issue(1'b1, 4'd1, 32'hFFFF_FFFD, 32'd5, 1'b1);
    idle_cycles(MULT_N + 1, 1'b0);
    issue(1'b1, 4'd8, 32'd0, 32'd0, 1'b0);

    // reset during the third busy cycle of a div
    issue(1'b1, 4'd3, 32'd100, 32'd7, 1'b0);
    idle_cycles(2, 1'b0);
    do_reset(1);
    idle_cycles(1, 1'b0);
    issue(1'b1, 4'd1, 32'd6, 32'd7, 1'b0);
    idle_cycles(MULT_N + 1, 1'b0);

    for (int i = 0; i < 250; i++) begin
      if (m_pend && cyc < m_commit && $urandom_range(0, 3) != 0) begin
        issue(1'b0, 4'd0, 32'd0, 32'd0, 1'($urandom_range(0, 1)));
      end else begin
        op = 4'($urandom_range(0, 15));
        v  = ($urandom_range(0, 7) != 0);
        rs = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 40)) - 32'd20;
        case ($urandom_range(0, 3))
          0:       rt = 32'd0;
          1:       rt = 32'($urandom_range(1, 9));
          2:       rt = 32'd0 - 32'($urandom_range(1, 9));
          default: rt = $urandom;
        endcase
        issue(v, op, rs, rt, 1'($urandom_range(0, 1)));
      end
    end

    idle_cycles(DIV_N + 3, 1'b0);
    check("mdq_drained", 32'(mdq.size()), 32'd0);
    check("rdq_drained", 32'(rdq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
